bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 26 ++
 rtl/arb_pick.sv | 33 +++
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned LOCK_W = 4;

    localparam logic [LOCK_W-1:0] LOCK_MAX = 4'd15;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    // One master's beat as presented to the Bridge
    typedef struct packed {
        logic [BUS_W-1:0] addr;
        logic             wen;
        logic [BUS_W-1:0] wdata;
    } beat_t;

endpackage

// File: rtl/arb_pick.sv
// Winner selection for requests seen while the bus is idle.
// ARB_RR_EN defined: ties go to the master that did not own the bus last; otherwise m0 wins ties.
module arb_pick
    import bus_pkg::*;
(
    input  logic   req0_i,
    input  logic   req1_i,
`ifdef ARB_RR_EN
    input  logic   last_m1_i,
`endif
    output state_e pick_o
);

    always_comb begin
        pick_o = IDLE;
`ifdef ARB_RR_EN
        if (req0_i && req1_i) begin
            pick_o = last_m1_i ? OWN0 : OWN1;
        end else if (req0_i) begin
            pick_o = OWN0;
        end else if (req1_i) begin
            pick_o = OWN1;
        end
`else
        if (req0_i) begin
            pick_o = OWN0;
        end else if (req1_i) begin
            pick_o = OWN1;
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with burst lock; muxes the owning master onto the Bridge port.
// ARB_RR_EN selects round-robin tie-break in idle; default build is fixed m0 priority.
module bus_arbiter
    import bus_pkg::*;
(
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic             m0_req,
    input  logic [BUS_W-1:0] m0_addr,
    input  logic             m0_wen,
    input  logic [BUS_W-1:0] m0_wdata,
    input  logic             m0_lock,
    output logic             m0_ack,
    output logic [BUS_W-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic [BUS_W-1:0] m1_addr,
    input  logic             m1_wen,
    input  logic [BUS_W-1:0] m1_wdata,
    input  logic             m1_lock,
    output logic             m1_ack,
    output logic [BUS_W-1:0] m1_rdata,
    output logic [BUS_W-1:0] Bus_addr,
    output logic             Bus_wen,
    output logic [BUS_W-1:0] Bus_wdata,
    input  logic [BUS_W-1:0] Bus_rdata,
    output logic [1:0]       owner
);

    state_e            state_q, state_d;
    state_e            pick;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]        rst_sync_q;
    logic              run;
    beat_t             m0_beat, m1_beat, bus_beat;

    // Reset asserts immediately and is released two edges after cpu_rst_n rises
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

`ifdef ARB_RR_EN
    logic last_m1_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            last_m1_q <= 1'b1;
        end else if (state_q == OWN0) begin
            last_m1_q <= 1'b0;
        end else if (state_q == OWN1) begin
            last_m1_q <= 1'b1;
        end
    end

    arb_pick u_pick (
        .req0_i    (m0_req & run),
        .req1_i    (m1_req & run),
        .last_m1_i (last_m1_q),
        .pick_o    (pick)
    );
`else
    arb_pick u_pick (
        .req0_i (m0_req & run),
        .req1_i (m1_req & run),
        .pick_o (pick)
    );
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Locked owner stays; otherwise hand over to the other master first, then re-grant, then idle
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        unique case (state_q)
            IDLE: state_d = pick;
            OWN0: begin
                if (m0_lock && (lock_cnt_q < LOCK_MAX)) begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end else if (m1_req) begin
                    state_d = OWN1;
                end else if (!m0_req) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (m1_lock && (lock_cnt_q < LOCK_MAX)) begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (!m1_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_beat = '{addr: m0_addr, wen: m0_wen, wdata: m0_wdata};
    assign m1_beat = '{addr: m1_addr, wen: m1_wen, wdata: m1_wdata};

    always_comb begin
        bus_beat = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        owner    = OWNER_IDLE;
        unique case (state_q)
            OWN0: begin
                bus_beat = m0_beat;
                m0_ack   = 1'b1;
                m0_rdata = Bus_rdata;
                owner    = OWNER_M0;
            end
            OWN1: begin
                bus_beat = m1_beat;
                m1_ack   = 1'b1;
                m1_rdata = Bus_rdata;
                owner    = OWNER_M1;
            end
            default: ;
        endcase
    end

    assign Bus_addr  = bus_beat.addr;
    assign Bus_wen   = bus_beat.wen;
    assign Bus_wdata = bus_beat.wdata;

endmodule
